// File: rtl/prm_edge_chk_sched.sv
// rtl/prm_edge_chk_sched.sv - PRM edge checker bank query sequencer
//
// Buffers configuration-code queries in a small FIFO and presents them one at a
// time on the shared checker bus. After SETTLE cycles it captures the bank mask,
// then returns mask, code and blocked-edge count over a valid/ready port.
//
// Optional feature macro: PRM_CHK_STATS_EN (adds stat_queries / stat_blocked).
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   q_valid/q_ready      query handshake, q_code = 15-bit configuration code
//   chk_code             registered code driven to every checker
//   chk_mask             per-checker edge_mask outputs of the bank
//   r_valid/r_ready      result handshake
//   r_mask, r_code       captured mask and the code that produced it
//   r_block_cnt          popcount of r_mask
//   stat_queries         (PRM_CHK_STATS_EN) result handshakes
//   stat_blocked         (PRM_CHK_STATS_EN) handshakes with r_block_cnt != 0
//   busy                 FIFO non-empty or FSM not idle
module prm_edge_chk_sched #(
  parameter int NUM_EDGE   = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int SETTLE     = 1,
  localparam int W         = $clog2(NUM_EDGE + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                q_valid,
  output logic                q_ready,
  input  logic [14:0]         q_code,
  output logic [14:0]         chk_code,
  input  logic [NUM_EDGE-1:0] chk_mask,
  output logic                r_valid,
  input  logic                r_ready,
  output logic [NUM_EDGE-1:0] r_mask,
  output logic [14:0]         r_code,
  output logic [W-1:0]        r_block_cnt,
`ifdef PRM_CHK_STATS_EN
  output logic [31:0]         stat_queries,
  output logic [31:0]         stat_blocked,
`endif
  output logic                busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

  typedef enum logic [1:0] {IDLE, SETTLING, RESULT} state_t;

  state_t          state, state_d;
  logic [14:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [SW-1:0]   cnt;
  logic            full, empty, push, pop, capture;
  logic [W-1:0]    pc;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  // A same-cycle pop never makes room for a push: q_ready looks only at full.
  assign q_ready = !full;
  assign push    = q_valid && q_ready;
  assign r_valid = (state == RESULT);
  assign busy    = !empty || (state != IDLE);

  always_comb begin
    pc = '0;
    for (int i = 0; i < NUM_EDGE; i++) pc = pc + W'(chk_mask[i]);
  end

  always_comb begin
    state_d = state;
    pop     = 1'b0;
    capture = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = SETTLING;
        end
      end
      SETTLING: begin
        if (cnt == SW'(1)) begin
          capture = 1'b1;
          state_d = RESULT;
        end
      end
      RESULT: begin
        if (r_ready) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = SETTLING;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= q_code;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      cnt         <= '0;
      chk_code    <= '0;
      r_mask      <= '0;
      r_code      <= '0;
      r_block_cnt <= '0;
    end else begin
      state <= state_d;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (pop) begin
        chk_code <= mem[rd_ptr];
        cnt      <= SW'(SETTLE);
      end else if (state == SETTLING) begin
        cnt <= cnt - SW'(1);
      end
      if (capture) begin
        r_mask      <= chk_mask;
        r_code      <= chk_code;
        r_block_cnt <= pc;
      end
    end
  end

`ifdef PRM_CHK_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_queries <= '0;
      stat_blocked <= '0;
    end else if (r_valid && r_ready) begin
      stat_queries <= stat_queries + 32'd1;
      if (r_block_cnt != '0) stat_blocked <= stat_blocked + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_prm_edge_chk_sched.sv
// tb/tb_prm_edge_chk_sched.sv - directed self-checking bench for prm_edge_chk_sched
module tb_prm_edge_chk_sched;

  logic        clk = 1'b0;
  logic        rst;
  int          checks = 0;
  int          errors = 0;

  // Instance a: SETTLE=1
  logic        a_q_valid, a_q_ready, a_r_valid, a_r_ready, a_busy, a_bank_en;
  logic [14:0] a_q_code, a_chk_code, a_r_code;
  logic [31:0] a_chk_mask, a_mask_drv, a_r_mask;
  logic [5:0]  a_r_block_cnt;
  // Instance b: SETTLE=3
  logic        b_q_valid, b_q_ready, b_r_valid, b_r_ready, b_busy, b_bank_en;
  logic [14:0] b_q_code, b_chk_code, b_r_code;
  logic [31:0] b_chk_mask, b_mask_drv, b_r_mask;
  logic [5:0]  b_r_block_cnt;
`ifdef PRM_CHK_STATS_EN
  logic [31:0] a_stat_queries, a_stat_blocked, b_stat_queries, b_stat_blocked;
`endif

  // Simple bank model: mask = zero-extended code, or a directly driven vector.
  assign a_chk_mask = a_bank_en ? {17'h0, a_chk_code} : a_mask_drv;
  assign b_chk_mask = b_bank_en ? {17'h0, b_chk_code} : b_mask_drv;

  always #5 clk = ~clk;

  prm_edge_chk_sched #(.NUM_EDGE(32), .FIFO_DEPTH(4), .SETTLE(1)) dut_a (
    .clk(clk), .rst(rst), .q_valid(a_q_valid), .q_ready(a_q_ready),
    .q_code(a_q_code), .chk_code(a_chk_code), .chk_mask(a_chk_mask),
    .r_valid(a_r_valid), .r_ready(a_r_ready), .r_mask(a_r_mask),
    .r_code(a_r_code), .r_block_cnt(a_r_block_cnt),
`ifdef PRM_CHK_STATS_EN
    .stat_queries(a_stat_queries), .stat_blocked(a_stat_blocked),
`endif
    .busy(a_busy));

  prm_edge_chk_sched #(.NUM_EDGE(32), .FIFO_DEPTH(4), .SETTLE(3)) dut_b (
    .clk(clk), .rst(rst), .q_valid(b_q_valid), .q_ready(b_q_ready),
    .q_code(b_q_code), .chk_code(b_chk_code), .chk_mask(b_chk_mask),
    .r_valid(b_r_valid), .r_ready(b_r_ready), .r_mask(b_r_mask),
    .r_code(b_r_code), .r_block_cnt(b_r_block_cnt),
`ifdef PRM_CHK_STATS_EN
    .stat_queries(b_stat_queries), .stat_blocked(b_stat_blocked),
`endif
    .busy(b_busy));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    a_q_valid = 0; a_q_code = '0; a_r_ready = 0; a_bank_en = 0; a_mask_drv = '0;
    b_q_valid = 0; b_q_code = '0; b_r_ready = 0; b_bank_en = 0; b_mask_drv = '0;
    #12;
    checks++; if (a_q_ready !== 1'b1) begin errors++; $display("FAIL reset_q_ready got %b want 1", a_q_ready); end
    checks++; if (a_r_valid !== 1'b0) begin errors++; $display("FAIL reset_r_valid got %b want 0", a_r_valid); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", a_busy); end
    checks++; if (a_chk_code !== 15'h0) begin errors++; $display("FAIL reset_chk_code got %h want 0", a_chk_code); end
    checks++; if (a_r_mask !== 32'h0) begin errors++; $display("FAIL reset_r_mask got %h want 0", a_r_mask); end
    checks++; if (a_r_code !== 15'h0) begin errors++; $display("FAIL reset_r_code got %h want 0", a_r_code); end
    checks++; if (a_r_block_cnt !== 6'd0) begin errors++; $display("FAIL reset_block_cnt got %0d want 0", a_r_block_cnt); end
    checks++; if (b_r_valid !== 1'b0 || b_busy !== 1'b0) begin errors++; $display("FAIL reset_b got valid %b busy %b want 0 0", b_r_valid, b_busy); end
    #3 rst = 1'b0;
    tick;
  endtask

  task automatic test_single;
    a_mask_drv = 32'h0000_0104;
    a_q_code = 15'h4A1B; a_q_valid = 1;
    tick;
    a_q_valid = 0;
    checks++; if (a_r_valid !== 1'b0) begin errors++; $display("FAIL single_valid_t got %b want 0", a_r_valid); end
    tick;
    checks++; if (a_chk_code !== 15'h4A1B) begin errors++; $display("FAIL single_chk_code got %h want 4a1b", a_chk_code); end
    checks++; if (a_r_valid !== 1'b0) begin errors++; $display("FAIL single_valid_t1 got %b want 0", a_r_valid); end
    tick;
    checks++; if (a_r_valid !== 1'b1) begin errors++; $display("FAIL single_valid_t2 got %b want 1", a_r_valid); end
    checks++; if (a_r_mask !== 32'h0000_0104) begin errors++; $display("FAIL single_mask got %h want 00000104", a_r_mask); end
    checks++; if (a_r_block_cnt !== 6'd2) begin errors++; $display("FAIL single_cnt got %0d want 2", a_r_block_cnt); end
    checks++; if (a_r_code !== 15'h4A1B) begin errors++; $display("FAIL single_r_code got %h want 4a1b", a_r_code); end
    a_r_ready = 1;
    tick;
    a_r_ready = 0;
    checks++; if (a_r_valid !== 1'b0 || a_busy !== 1'b0) begin errors++; $display("FAIL single_done got valid %b busy %b want 0 0", a_r_valid, a_busy); end
  endtask

  task automatic test_fifo_full;
    logic [14:0] codes [6];
    logic [5:0]  cnts [6];
    int k;
    logic hs, pushing;
    codes[0] = 15'h0001; cnts[0] = 6'd1;
    codes[1] = 15'h0003; cnts[1] = 6'd2;
    codes[2] = 15'h0007; cnts[2] = 6'd3;
    codes[3] = 15'h000F; cnts[3] = 6'd4;
    codes[4] = 15'h001F; cnts[4] = 6'd5;
    codes[5] = 15'h7FFF; cnts[5] = 6'd15;
    a_bank_en = 1; a_r_ready = 0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (a_q_ready !== 1'b1) begin errors++; $display("FAIL fill_q_ready_%0d got %b want 1", i, a_q_ready); end
      a_q_code = codes[i]; a_q_valid = 1;
      tick;
    end
    a_q_code = codes[5];
    checks++; if (a_q_ready !== 1'b0) begin errors++; $display("FAIL full_q_ready got %b want 0", a_q_ready); end
    repeat (3) tick;
    checks++; if (a_q_ready !== 1'b0) begin errors++; $display("FAIL full_hold got %b want 0", a_q_ready); end
    checks++; if (a_r_valid !== 1'b1 || a_r_code !== codes[0]) begin errors++; $display("FAIL full_result got valid %b code %h want 1 %h", a_r_valid, a_r_code, codes[0]); end
    a_r_ready = 1;
    k = 0;
    for (int cyc = 0; cyc < 60 && k < 6; cyc++) begin
      hs = a_r_valid && a_r_ready;
      pushing = a_q_valid && a_q_ready;
      if (hs) begin
        checks++; if (a_r_code !== codes[k]) begin errors++; $display("FAIL order_code_%0d got %h want %h", k, a_r_code, codes[k]); end
        checks++; if (a_r_block_cnt !== cnts[k]) begin errors++; $display("FAIL order_cnt_%0d got %0d want %0d", k, a_r_block_cnt, cnts[k]); end
        checks++; if (a_r_mask !== {17'h0, codes[k]}) begin errors++; $display("FAIL order_mask_%0d got %h want %h", k, a_r_mask, {17'h0, codes[k]}); end
      end
      tick;
      if (pushing) a_q_valid = 0;
      if (hs) k++;
    end
    a_q_valid = 0;
    checks++; if (k !== 6) begin errors++; $display("FAIL order_count got %0d want 6", k); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL order_busy got %b want 0", a_busy); end
    a_r_ready = 0;
  endtask

  task automatic test_back_to_back;
    logic [14:0] codes [3];
    int k, last;
    logic chk_next;
    codes[0] = 15'h0A0A; codes[1] = 15'h1B1B; codes[2] = 15'h2C2C;
    b_bank_en = 1; b_r_ready = 1;
    for (int i = 0; i < 3; i++) begin
      b_q_code = codes[i]; b_q_valid = 1;
      tick;
    end
    b_q_valid = 0;
    k = 0; last = 0; chk_next = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (chk_next) begin
        chk_next = 0;
        checks++; if (b_chk_code !== codes[k]) begin errors++; $display("FAIL b2b_chk_code_%0d got %h want %h", k, b_chk_code, codes[k]); end
      end
      if (b_r_valid) begin
        if (k < 3) begin
          checks++; if (b_r_code !== codes[k]) begin errors++; $display("FAIL b2b_code_%0d got %h want %h", k, b_r_code, codes[k]); end
        end
        if (k > 0) begin
          checks++; if (cyc - last !== 4) begin errors++; $display("FAIL b2b_spacing_%0d got %0d want 4", k, cyc - last); end
        end
        last = cyc;
        k++;
        if (k < 3) chk_next = 1;
      end
      tick;
    end
    checks++; if (k !== 3) begin errors++; $display("FAIL b2b_pulses got %0d want 3", k); end
    checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL b2b_busy got %b want 0", b_busy); end
    b_r_ready = 0;
  endtask

  task automatic test_mask_toggle;
    b_bank_en = 0; b_r_ready = 0; b_mask_drv = 32'h0;
    b_q_code = 15'h1234; b_q_valid = 1;
    tick;
    b_q_valid = 0;
    tick;
    checks++; if (b_chk_code !== 15'h1234) begin errors++; $display("FAIL tog_chk_code got %h want 1234", b_chk_code); end
    b_mask_drv = 32'hFFFF_0000;
    tick;
    b_mask_drv = 32'h0000_00FF;
    tick;
    checks++; if (b_r_valid !== 1'b0) begin errors++; $display("FAIL tog_early_valid got %b want 0", b_r_valid); end
    b_mask_drv = 32'hFFFF_FFFF;
    tick;
    b_mask_drv = 32'h0;
    checks++; if (b_r_valid !== 1'b1) begin errors++; $display("FAIL tog_valid got %b want 1", b_r_valid); end
    checks++; if (b_r_mask !== 32'hFFFF_FFFF) begin errors++; $display("FAIL tog_mask got %h want ffffffff", b_r_mask); end
    checks++; if (b_r_block_cnt !== 6'd32) begin errors++; $display("FAIL tog_cnt got %0d want 32", b_r_block_cnt); end
    checks++; if (b_r_code !== 15'h1234) begin errors++; $display("FAIL tog_code got %h want 1234", b_r_code); end
    tick;
    checks++; if (b_r_mask !== 32'hFFFF_FFFF) begin errors++; $display("FAIL tog_hold got %h want ffffffff", b_r_mask); end
    b_r_ready = 1;
    tick;
    b_r_ready = 0;
    checks++; if (b_r_valid !== 1'b0) begin errors++; $display("FAIL tog_release got %b want 0", b_r_valid); end
  endtask

  task automatic test_reset_mid;
    a_bank_en = 1; a_r_ready = 0;
    a_q_valid = 1;
    a_q_code = 15'h0101; tick;
    a_q_code = 15'h0202; tick;
    a_q_code = 15'h0303; tick;
    a_q_valid = 0;
    checks++; if (a_r_valid !== 1'b1 || a_busy !== 1'b1) begin errors++; $display("FAIL rmid_pre got valid %b busy %b want 1 1", a_r_valid, a_busy); end
    #2 rst = 1'b1;
    #1;
    checks++; if (a_r_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b want 0", a_r_valid); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", a_busy); end
    checks++; if (a_chk_code !== 15'h0) begin errors++; $display("FAIL rmid_chk_code got %h want 0", a_chk_code); end
    checks++; if (a_q_ready !== 1'b1) begin errors++; $display("FAIL rmid_q_ready got %b want 1", a_q_ready); end
    #2 rst = 1'b0;
    tick;
    a_q_code = 15'h7001; a_q_valid = 1;
    tick;
    a_q_valid = 0;
    checks++; if (a_chk_code !== 15'h0) begin errors++; $display("FAIL rmid_no_stale got %h want 0", a_chk_code); end
    tick;
    checks++; if (a_chk_code !== 15'h7001) begin errors++; $display("FAIL rmid_new_code got %h want 7001", a_chk_code); end
    tick;
    checks++; if (a_r_valid !== 1'b1 || a_r_code !== 15'h7001 || a_r_block_cnt !== 6'd4) begin
      errors++; $display("FAIL rmid_result got valid %b code %h cnt %0d want 1 7001 4", a_r_valid, a_r_code, a_r_block_cnt);
    end
    a_r_ready = 1;
    tick;
    a_r_ready = 0;
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL rmid_drain got %b want 0", a_busy); end
  endtask

`ifdef PRM_CHK_STATS_EN
  task automatic test_stats;
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    tick;
    a_bank_en = 1; a_r_ready = 1;
    a_q_valid = 1;
    a_q_code = 15'h0000; tick;
    a_q_code = 15'h001F; tick;
    a_q_code = 15'h0100; tick;
    a_q_valid = 0;
    for (int cyc = 0; cyc < 30 && a_busy; cyc++) tick;
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL stats_timeout busy %b want 0", a_busy); end
    checks++; if (a_stat_queries !== 32'd3) begin errors++; $display("FAIL stat_queries got %0d want 3", a_stat_queries); end
    checks++; if (a_stat_blocked !== 32'd2) begin errors++; $display("FAIL stat_blocked got %0d want 2", a_stat_blocked); end
    a_r_ready = 0;
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_fifo_full;
    test_back_to_back;
    test_mask_toggle;
    test_reset_mid;
`ifdef PRM_CHK_STATS_EN
    test_stats;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
